chacha_aead_seq: RTL and testbench

Sequencing controller for `chacha20_poly1305_core`. It takes one AEAD job from the host, configures the core, and fetches the Poly1305 key block. It then streams AAD and payload blocks into the core one block at a time and counts their bytes. Finally it builds and sends the length block, waits for the tag halves, and returns the combined 128-bit tag.

---
 rtl/chacha_aead_pkg.sv | 31 +++
 rtl/aead_tag_combine.sv | 64 ++++++
 rtl/chacha_aead_seq.sv | 212 +++++++++++++++++++++
 tb/tb_chacha_aead_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_aead_pkg.sv
// Shared types and helpers for the ChaCha20-Poly1305 AEAD job sequencer.
package chacha_aead_pkg;

   localparam int LEN_W = 64;
   localparam int BLK_W = 128;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_CFG      = 4'd1,
      S_KSREQ    = 4'd2,
      S_KSWAIT   = 4'd3,
      S_AAD_SEND = 4'd4,
      S_AAD_WAIT = 4'd5,
      S_PLD_SEND = 4'd6,
      S_PLD_WAIT = 4'd7,
      S_LEN_SEND = 4'd8,
      S_LEN_WAIT = 4'd9,
      S_TAG_WAIT = 4'd10,
      S_DONE     = 4'd11
   } state_e;

   function automatic logic [4:0] popcount16(input logic [15:0] keep);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, keep[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/aead_tag_combine.sv
// Holds the two tag halves as they arrive (in any order) and merges them
// into the final tag by modular add (ChaCha) or XOR (GCM-style).
module aead_tag_combine
   import chacha_aead_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_algo,
   input  logic [BLK_W-1:0] i_pre,
   input  logic             i_pre_valid,
   input  logic [BLK_W-1:0] i_mask,
   input  logic             i_mask_valid,
   output logic             o_both,
   output logic [BLK_W-1:0] o_tag
);

   logic             r_pre_v;
   logic             r_mask_v;
   logic [BLK_W-1:0] r_pre;
   logic [BLK_W-1:0] r_mask;
   logic [BLK_W-1:0] r_tag;
   logic             w_pre_v;
   logic             w_mask_v;
   logic [BLK_W-1:0] w_pre;
   logic [BLK_W-1:0] w_mask;
   logic [BLK_W-1:0] w_tag;

   // a half arriving this cycle counts as held, so both-at-once costs no extra cycle
   assign w_pre_v  = r_pre_v || (i_en && i_pre_valid);
   assign w_mask_v = r_mask_v || (i_en && i_mask_valid);
   assign w_pre    = r_pre_v ? r_pre : i_pre;
   assign w_mask   = r_mask_v ? r_mask : i_mask;
   assign o_both   = i_en && w_pre_v && w_mask_v;
   assign w_tag    = i_algo ? (w_pre + w_mask) : (w_pre ^ w_mask);
   assign o_tag    = r_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_v  <= 1'b0;
         r_mask_v <= 1'b0;
         r_pre    <= {BLK_W{1'b0}};
         r_mask   <= {BLK_W{1'b0}};
         r_tag    <= {BLK_W{1'b0}};
      end else if (i_clr) begin
         r_pre_v  <= 1'b0;
         r_mask_v <= 1'b0;
      end else begin
         if (i_en && i_pre_valid && !r_pre_v) begin
            r_pre_v <= 1'b1;
            r_pre   <= i_pre;
         end
         if (i_en && i_mask_valid && !r_mask_v) begin
            r_mask_v <= 1'b1;
            r_mask   <= i_mask;
         end
         if (o_both) begin
            r_tag <= w_tag;
         end
      end
   end

endmodule

// File: rtl/chacha_aead_seq.sv
// Single-job AEAD sequencer: configures the core, streams AAD/payload blocks,
// sends the length block and returns the combined tag, with a wait watchdog.
module chacha_aead_seq
   import chacha_aead_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CW             = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [255:0]     cfg_key,
   input  logic [95:0]      cfg_nonce,
   input  logic [31:0]      cfg_ctr,
   input  logic             cfg_algo,
   input  logic             aad_empty,
   input  logic             pld_empty,
   input  logic             s_aad_valid,
   input  logic [BLK_W-1:0] s_aad_data,
   input  logic [15:0]      s_aad_keep,
   input  logic             s_aad_last,
   output logic             s_aad_ready,
   input  logic             s_pld_valid,
   input  logic [BLK_W-1:0] s_pld_data,
   input  logic [15:0]      s_pld_keep,
   input  logic             s_pld_last,
   output logic             s_pld_ready,
   output logic [BLK_W-1:0] tag,
   output logic             tag_valid,
   output logic             busy,
   output logic             err_timeout,
   output logic [255:0]     key,
   output logic [95:0]      nonce,
   output logic [31:0]      ctr_init,
   output logic             cfg_we,
   output logic             ks_req,
   output logic             aad_valid,
   output logic [BLK_W-1:0] aad_data,
   output logic [15:0]      aad_keep,
   output logic             pld_valid,
   output logic [BLK_W-1:0] pld_data,
   output logic [15:0]      pld_keep,
   output logic             len_valid,
   output logic [BLK_W-1:0] len_block,
   output logic             algo_sel,
   input  logic             ks_valid,
   input  logic             aad_ready,
   input  logic             pld_ready,
   input  logic             len_ready,
   input  logic             aad_done,
   input  logic             pld_done,
   input  logic             lens_done,
   input  logic [BLK_W-1:0] tag_pre_xor,
   input  logic             tag_pre_xor_valid,
   input  logic [BLK_W-1:0] tagmask,
   input  logic             tagmask_valid
);

   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [255:0]     r_key;
   logic [95:0]      r_nonce;
   logic [31:0]      r_ctr;
   logic             r_algo;
   logic             r_aad_empty;
   logic             r_pld_empty;
   logic             r_last;
   logic             r_err;
   logic [LEN_W-1:0] r_aad_bytes;
   logic [LEN_W-1:0] r_pld_bytes;
   logic [CW-1:0]    r_wd;
   logic             w_start_acc;
   logic             w_aad_st;
   logic             w_pld_st;
   logic             w_aad_xfer;
   logic             w_pld_xfer;
   logic             w_wd_en;
   logic             w_timeout;
   logic             w_tag_both;

   assign w_start_acc = (r_state == S_IDLE) && start;
   assign w_aad_st    = (r_state == S_AAD_SEND);
   assign w_pld_st    = (r_state == S_PLD_SEND);
   assign w_aad_xfer  = w_aad_st && s_aad_valid && aad_ready;
   assign w_pld_xfer  = w_pld_st && s_pld_valid && pld_ready;
   assign w_wd_en     = r_state inside {S_KSWAIT, S_AAD_WAIT, S_PLD_WAIT,
                                        S_LEN_SEND, S_LEN_WAIT, S_TAG_WAIT};
   assign w_timeout   = w_wd_en && (r_wd == WD_LAST);

   always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     w_state_nxt = start ? S_CFG : S_IDLE;
            S_CFG:      w_state_nxt = S_KSREQ;
            S_KSREQ:    w_state_nxt = S_KSWAIT;
            S_KSWAIT:   w_state_nxt = !ks_valid ? S_KSWAIT :
                                      !r_aad_empty ? S_AAD_SEND :
                                      !r_pld_empty ? S_PLD_SEND : S_LEN_SEND;
            S_AAD_SEND: w_state_nxt = w_aad_xfer ? S_AAD_WAIT : S_AAD_SEND;
            S_AAD_WAIT: w_state_nxt = !aad_done ? S_AAD_WAIT :
                                      !r_last ? S_AAD_SEND :
                                      r_pld_empty ? S_LEN_SEND : S_PLD_SEND;
            S_PLD_SEND: w_state_nxt = w_pld_xfer ? S_PLD_WAIT : S_PLD_SEND;
            S_PLD_WAIT: w_state_nxt = !pld_done ? S_PLD_WAIT :
                                      r_last ? S_LEN_SEND : S_PLD_SEND;
            S_LEN_SEND: w_state_nxt = len_ready ? S_LEN_WAIT : S_LEN_SEND;
            S_LEN_WAIT: w_state_nxt = lens_done ? S_TAG_WAIT : S_LEN_WAIT;
            S_TAG_WAIT: w_state_nxt = w_tag_both ? S_DONE : S_TAG_WAIT;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // watchdog restarts on every state change, so each wait gets its own budget
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd <= {CW{1'b0}};
      end else if (w_state_nxt != r_state) begin
         r_wd <= {CW{1'b0}};
      end else if (w_wd_en) begin
         r_wd <= r_wd + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key       <= 256'd0;
         r_nonce     <= 96'd0;
         r_ctr       <= 32'd0;
         r_algo      <= 1'b0;
         r_aad_empty <= 1'b0;
         r_pld_empty <= 1'b0;
         r_last      <= 1'b0;
         r_err       <= 1'b0;
         r_aad_bytes <= {LEN_W{1'b0}};
         r_pld_bytes <= {LEN_W{1'b0}};
      end else begin
         if (w_start_acc) begin
            r_key       <= cfg_key;
            r_nonce     <= cfg_nonce;
            r_ctr       <= cfg_ctr;
            r_algo      <= cfg_algo;
            r_aad_empty <= aad_empty;
            r_pld_empty <= pld_empty;
            r_err       <= 1'b0;
            r_aad_bytes <= {LEN_W{1'b0}};
            r_pld_bytes <= {LEN_W{1'b0}};
         end else if (w_timeout) begin
            r_err <= 1'b1;
         end
         if (w_aad_xfer) begin
            r_aad_bytes <= r_aad_bytes + {{(LEN_W-5){1'b0}}, popcount16(s_aad_keep)};
            r_last      <= s_aad_last;
         end
         if (w_pld_xfer) begin
            r_pld_bytes <= r_pld_bytes + {{(LEN_W-5){1'b0}}, popcount16(s_pld_keep)};
            r_last      <= s_pld_last;
         end
      end
   end

   aead_tag_combine u_tag (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clr        (w_start_acc),
      .i_en         (r_state == S_TAG_WAIT),
      .i_algo       (r_algo),
      .i_pre        (tag_pre_xor),
      .i_pre_valid  (tag_pre_xor_valid),
      .i_mask       (tagmask),
      .i_mask_valid (tagmask_valid),
      .o_both       (w_tag_both),
      .o_tag        (tag)
   );

   // host streams see the core's ready directly, gated to their own SEND state
   assign s_aad_ready = w_aad_st && aad_ready;
   assign aad_valid   = w_aad_st && s_aad_valid;
   assign aad_data    = w_aad_st ? s_aad_data : {BLK_W{1'b0}};
   assign aad_keep    = w_aad_st ? s_aad_keep : 16'd0;
   assign s_pld_ready = w_pld_st && pld_ready;
   assign pld_valid   = w_pld_st && s_pld_valid;
   assign pld_data    = w_pld_st ? s_pld_data : {BLK_W{1'b0}};
   assign pld_keep    = w_pld_st ? s_pld_keep : 16'd0;

   assign len_valid   = (r_state == S_LEN_SEND);
   assign len_block   = {r_pld_bytes, r_aad_bytes};
   assign cfg_we      = (r_state == S_CFG);
   assign ks_req      = (r_state == S_KSREQ);
   assign tag_valid   = (r_state == S_DONE);
   assign busy        = (r_state != S_IDLE);
   assign err_timeout = r_err;
   assign key         = r_key;
   assign nonce       = r_nonce;
   assign ctr_init    = r_ctr;
   assign algo_sel    = r_algo;

endmodule

// File: tb/tb_chacha_aead_seq.sv
// Directed bench for chacha_aead_seq with a bench-driven core model and host streams.
module tb_chacha_aead_seq;

   localparam int TO = 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [255:0]  cfg_key = 256'd0;
   logic [95:0]   cfg_nonce = 96'd0;
   logic [31:0]   cfg_ctr = 32'd0;
   logic          cfg_algo = 1'b0, aad_empty = 1'b0, pld_empty = 1'b0;
   logic          s_aad_valid = 1'b0, s_aad_last = 1'b0, s_aad_ready;
   logic [127:0]  s_aad_data = 128'd0;
   logic [15:0]   s_aad_keep = 16'd0;
   logic          s_pld_valid = 1'b0, s_pld_last = 1'b0, s_pld_ready;
   logic [127:0]  s_pld_data = 128'd0;
   logic [15:0]   s_pld_keep = 16'd0;
   logic [127:0]  tag, aad_data, pld_data, len_block;
   logic          tag_valid, busy, err_timeout, cfg_we, ks_req, aad_valid, pld_valid, len_valid, algo_sel;
   logic [255:0]  key;
   logic [95:0]   nonce;
   logic [31:0]   ctr_init;
   logic [15:0]   aad_keep, pld_keep;
   logic          ks_valid = 1'b1, aad_ready = 1'b1, pld_ready = 1'b1, len_ready = 1'b1;
   logic          aad_done = 1'b1, pld_done = 1'b1, lens_done = 1'b1;
   logic [127:0]  tag_pre_xor = 128'hffffffff_ffffffff_ffffffff_fffffff0;
   logic [127:0]  tagmask = 128'h00000000_00000000_00000000_00000020;
   logic          tag_pre_xor_valid = 1'b1, tagmask_valid = 1'b1;

   int            n_checks = 0;
   int            n_errors = 0;
   int            tv_cnt = 0;
   int            rdy_cnt = 0;
   logic [127:0]  len_cap = 128'd0;

   localparam logic [255:0] KEY_A = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
   localparam logic [127:0] TAG_ADD = 128'h00000000_00000000_00000000_00000010;

   chacha_aead_seq #(.TIMEOUT_CYCLES(TO), .CW(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
      .cfg_ctr(cfg_ctr), .cfg_algo(cfg_algo), .aad_empty(aad_empty), .pld_empty(pld_empty),
      .s_aad_valid(s_aad_valid), .s_aad_data(s_aad_data), .s_aad_keep(s_aad_keep),
      .s_aad_last(s_aad_last), .s_aad_ready(s_aad_ready),
      .s_pld_valid(s_pld_valid), .s_pld_data(s_pld_data), .s_pld_keep(s_pld_keep),
      .s_pld_last(s_pld_last), .s_pld_ready(s_pld_ready),
      .tag(tag), .tag_valid(tag_valid), .busy(busy), .err_timeout(err_timeout),
      .key(key), .nonce(nonce), .ctr_init(ctr_init), .cfg_we(cfg_we), .ks_req(ks_req),
      .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep),
      .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep),
      .len_valid(len_valid), .len_block(len_block), .algo_sel(algo_sel),
      .ks_valid(ks_valid), .aad_ready(aad_ready), .pld_ready(pld_ready), .len_ready(len_ready),
      .aad_done(aad_done), .pld_done(pld_done), .lens_done(lens_done),
      .tag_pre_xor(tag_pre_xor), .tag_pre_xor_valid(tag_pre_xor_valid),
      .tagmask(tagmask), .tagmask_valid(tagmask_valid)
   );

   always #5 clk = ~clk;

   // observe pulses and the length block on the quiet clock edge
   always @(negedge clk) begin
      if (tag_valid === 1'b1) tv_cnt <= tv_cnt + 1;
      if ((s_aad_ready === 1'b1) || (s_pld_ready === 1'b1)) rdy_cnt <= rdy_cnt + 1;
      if (len_valid === 1'b1) len_cap <= len_block;
   end

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic start_job(input bit algo, input bit ae, input bit pe);
      cfg_key   = KEY_A;
      cfg_nonce = 96'hcafebabe_00112233_44556677;
      cfg_ctr   = 32'd1;
      cfg_algo  = algo;
      aad_empty = ae;
      pld_empty = pe;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic send_blk(input bit is_pld, input logic [127:0] d, input logic [15:0] k, input bit last);
      int n;
      n = 0;
      if (is_pld) begin
         s_pld_valid = 1'b1; s_pld_data = d; s_pld_keep = k; s_pld_last = last;
      end else begin
         s_aad_valid = 1'b1; s_aad_data = d; s_aad_keep = k; s_aad_last = last;
      end
      #1;
      while (((is_pld ? s_pld_ready : s_aad_ready) !== 1'b1) && (n < 100)) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("send_accept", n < 100, 1'b1);
      chk("pass_data", is_pld ? {pld_keep, pld_data} : {aad_keep, aad_data}, {k, d});
      @(negedge clk);
      s_pld_valid = 1'b0;
      s_aad_valid = 1'b0;
   endtask

   task automatic wait_tag(input string nm, input logic [127:0] exp);
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && (n < 200)) begin
         @(negedge clk);
         n++;
         if (tag_valid === 1'b1) begin
            seen = 1'b1;
            chk({nm, "_tag"}, tag, exp);
         end
      end
      chk({nm, "_tv_seen"}, seen, 1'b1);
   endtask

   task automatic job_t1(input string nm);
      int base;
      base = tv_cnt;
      start_job(1'b1, 1'b0, 1'b0);
      chk({nm, "_cfg_we"}, cfg_we, 1'b1);
      chk({nm, "_cfg"}, {key, algo_sel}, {KEY_A, 1'b1});
      send_blk(1'b0, 128'h11111111_22222222_33333333_44444444, 16'hffff, 1'b1);
      send_blk(1'b1, 128'h55555555_66666666_77777777_88888888, 16'hffff, 1'b1);
      wait_tag(nm, TAG_ADD);
      repeat (3) @(negedge clk);
      chk({nm, "_len"}, len_cap, 128'h0000000000000010_0000000000000010);
      chk({nm, "_pulses"}, tv_cnt - base, 1);
      chk({nm, "_idle"}, {busy, err_timeout}, 2'b00);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1);
   end

   initial begin
      int base, first_k, n_tv, n;
      logic [127:0] tag_got;
      bit gone;

      repeat (3) @(negedge clk);
      chk("rst_ctl", {busy, tag_valid, err_timeout, cfg_we, ks_req, len_valid, algo_sel}, 7'd0);
      chk("rst_data", {tag, len_block}, 256'd0);
      chk("rst_key", key, 256'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: one full AAD and one full payload block, add-combine with carry wrap
      job_t1("t1");

      // 2: partial keeps, 35 AAD bytes and 8 payload bytes
      start_job(1'b1, 1'b0, 1'b0);
      send_blk(1'b0, 128'hA1, 16'hffff, 1'b0);
      send_blk(1'b0, 128'hA2, 16'hffff, 1'b0);
      send_blk(1'b0, 128'hA3, 16'h0007, 1'b1);
      send_blk(1'b1, 128'hB1, 16'h00ff, 1'b1);
      wait_tag("t2", TAG_ADD);
      repeat (2) @(negedge clk);
      chk("t2_len", len_cap, {64'd8, 64'd35});

      // 3: empty job, minimum latency and no host handshake
      base = rdy_cnt;
      first_k = 0;
      cfg_algo = 1'b1; aad_empty = 1'b1; pld_empty = 1'b1; start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 1) chk("t3_cfg_we1", cfg_we, 1'b1);
         if (k == 2) chk("t3_cfg_we_once", {cfg_we, ks_req}, 2'b01);
         if (k == 3) chk("t3_ks_req_once", ks_req, 1'b0);
         if ((tag_valid === 1'b1) && (first_k == 0)) first_k = k;
      end
      chk("t3_latency", first_k, 7);
      chk("t3_no_ready", rdy_cnt - base, 0);
      chk("t3_len", len_cap, 128'd0);

      // 4: XOR combine, mask half arrives five cycles before pre half
      tag_pre_xor_valid = 1'b0; tagmask_valid = 1'b0;
      tag_pre_xor = 128'hdeaddead_deaddead_deaddead_deaddead;
      tagmask     = 128'hffffffffffffffff_0000000000000000;
      n_tv = 0; first_k = 0; tag_got = 128'd0;
      cfg_algo = 1'b0; start = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (tag_valid === 1'b1) begin
            n_tv++;
            first_k = k;
            tag_got = tag;
         end
         if (k == 1) start = 1'b0;
         if (k == 6) tagmask_valid = 1'b1;
         if (k == 7) begin tagmask_valid = 1'b0; tagmask = 128'h5a5a; end
         if (k == 11) begin tag_pre_xor_valid = 1'b1; tag_pre_xor = 128'h0123456789abcdef_0123456789abcdef; end
         if (k == 12) begin tag_pre_xor_valid = 1'b0; tag_pre_xor = 128'h77; end
      end
      chk("t4_tag", tag_got, 128'hfedcba9876543210_0123456789abcdef);
      chk("t4_one_pulse", n_tv, 1);
      chk("t4_pulse_cycle", first_k, 12);
      tag_pre_xor = 128'hffffffff_ffffffff_ffffffff_fffffff0;
      tagmask     = 128'h00000000_00000000_00000000_00000020;
      tag_pre_xor_valid = 1'b1; tagmask_valid = 1'b1;

      // 5: core never finishes the AAD block, watchdog aborts
      base = tv_cnt;
      aad_done = 1'b0;
      start_job(1'b1, 1'b0, 1'b1);
      send_blk(1'b0, 128'hC1, 16'hffff, 1'b1);
      repeat (20) @(negedge clk);
      chk("t5_early", {busy, err_timeout}, 2'b10);
      gone = 1'b0;
      n = 0;
      while (!gone && (n < 100)) begin
         @(negedge clk);
         n++;
         if (busy === 1'b0) gone = 1'b1;
      end
      chk("t5_aborted", gone, 1'b1);
      chk("t5_err", {err_timeout, aad_valid, tag_valid}, 3'b100);
      repeat (2) @(negedge clk);
      chk("t5_no_tag", tv_cnt - base, 0);
      aad_done = 1'b1;
      start_job(1'b1, 1'b0, 1'b1);
      chk("t5_err_clr", err_timeout, 1'b0);
      send_blk(1'b0, 128'hC2, 16'h0fff, 1'b1);
      wait_tag("t5b", TAG_ADD);
      repeat (2) @(negedge clk);
      chk("t5b_len", len_cap, {64'd0, 64'd12});

      // 6: reset dropped while waiting on the payload block
      pld_done = 1'b0;
      start_job(1'b1, 1'b0, 1'b0);
      send_blk(1'b0, 128'hD1, 16'hffff, 1'b1);
      send_blk(1'b1, 128'hD2, 16'hffff, 1'b1);
      repeat (2) @(negedge clk);
      chk("t6_pre_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ctl", {busy, tag_valid, err_timeout, pld_valid, len_valid, algo_sel}, 6'd0);
      chk("t6_rst_data", {tag, len_block}, 256'd0);
      chk("t6_rst_key", key, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pld_done = 1'b1;
      @(negedge clk);
      job_t1("t6");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
